// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory bus bridge: access sizes,
// fault codes, FSM state type and the alignment rule.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_BUSERR   = 2'b10;
    localparam logic [1:0] FC_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Size code 11 falls into the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic v;
        v = 1'b0;
        case (size)
            SZ_BYTE: v = 1'b0;
            SZ_HALF: v = addr_lo[0];
            default: v = (addr_lo != 2'b00);
        endcase
        return v;
    endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Valid/ready memory bus between the bridge (master) and the memory (slave).
interface dmem_bridge_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        output bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
        input  bus_req_ready, bus_rsp_valid, bus_rdata, bus_err
    );

    modport slave (
        input  bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
        output bus_req_ready, bus_rsp_valid, bus_rdata, bus_err
    );
endinterface

// File: rtl/dmem_lane.sv
// Byte-lane steering: byte enables and replicated store data going out,
// read data shifted down to bit 0 coming back.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    // Lane selection by access size; size 11 behaves as word
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = (i_rdata >> {i_addr_lo, 3'b000}) & 32'h0000_00FF;
            end
            SZ_HALF: begin
                o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = (i_rdata >> {i_addr_lo[1], 4'b0000}) & 32'h0000_FFFF;
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// Runs one valid/ready bus transaction per load/store of the single-cycle
// datapath, stalling it while the access is in flight.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [1:0]    Size,
    input  logic [31:0]   Mem_WrAddr,
    input  logic [31:0]   Mem_WrData,
    output logic [31:0]   ReadData,
    output logic          Stall,
    output logic          Fault,
    output logic [1:0]    FaultCode,
    dmem_bridge_if.master bus
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_size;
    logic [1:0]  r_addr_lo;
    logic        r_we;
    logic        r_req_valid;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rdata;
    logic        r_fault;
    logic [1:0]  r_fault_code;
    logic [15:0] r_cnt;

    logic        w_access;
    logic        w_misalign;
    logic        w_timeout;
    logic        w_launch;
    logic [1:0]  w_lane_size;
    logic [1:0]  w_lane_lo;
    logic [1:0]  w_done_code;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;

    assign w_access    = MemRead | MemWrite;
    assign w_misalign  = is_misaligned(Size, Mem_WrAddr[1:0]);
    assign w_timeout   = (r_cnt == CNT_LAST);
    assign w_launch    = (r_state == ST_IDLE) && w_access;
    // Lanes follow the live inputs while launching and the captured access afterwards
    assign w_lane_size = (r_state == ST_IDLE) ? Size : r_size;
    assign w_lane_lo   = (r_state == ST_IDLE) ? Mem_WrAddr[1:0] : r_addr_lo;

    dmem_lane u_lane (
        .i_size    (w_lane_size),
        .i_addr_lo (w_lane_lo),
        .i_wdata   (Mem_WrData),
        .i_rdata   (bus.bus_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_rdata   (w_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; DONE always falls back to IDLE so nothing relaunches
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_access) w_next = w_misalign ? ST_DONE : ST_REQ;
                     else          w_next = ST_IDLE;
            ST_REQ:  if (bus.bus_req_ready) w_next = ST_RESP;
                     else                   w_next = ST_REQ;
            ST_RESP: if (bus.bus_rsp_valid || w_timeout) w_next = ST_DONE;
                     else                                w_next = ST_RESP;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Stall output: held low throughout reset
    always_comb begin
        Stall = 1'b0;
        if (!reset) begin
            Stall = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: Stall = w_access;
                ST_REQ:  Stall = 1'b1;
                ST_RESP: Stall = 1'b1;
                ST_DONE: Stall = 1'b0;
                default: Stall = 1'b0;
            endcase
        end
    end

    // Fault code to report on entry to DONE; a response beats the timeout
    always_comb begin
        w_done_code = FC_NONE;
        if (w_launch && w_misalign) begin
            w_done_code = FC_MISALIGN;
        end else if (r_state == ST_RESP && bus.bus_rsp_valid) begin
            w_done_code = bus.bus_err ? FC_BUSERR : FC_NONE;
        end else if (r_state == ST_RESP && w_timeout) begin
            w_done_code = FC_TIMEOUT;
        end else begin
            w_done_code = FC_NONE;
        end
    end

    // Request capture, read-data capture and the one-cycle fault report
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_size       <= 2'b00;
            r_addr_lo    <= 2'b00;
            r_we         <= 1'b0;
            r_req_valid  <= 1'b0;
            r_addr       <= 32'h0000_0000;
            r_wdata      <= 32'h0000_0000;
            r_be         <= 4'b0000;
            r_rdata      <= 32'h0000_0000;
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
        end else begin
            r_req_valid  <= (w_next == ST_REQ);
            r_fault      <= (w_next == ST_DONE) && (w_done_code != FC_NONE);
            r_fault_code <= (w_next == ST_DONE) ? w_done_code : FC_NONE;
            if (w_launch) begin
                r_size    <= Size;
                r_addr_lo <= Mem_WrAddr[1:0];
            end
            if (w_launch && !w_misalign) begin
                r_addr  <= {Mem_WrAddr[31:2], 2'b00};
                r_wdata <= w_wdata;
                r_be    <= w_be;
                r_we    <= MemWrite;
            end
            if (w_launch && w_misalign) begin
                r_rdata <= 32'h0000_0000;
            end else if (r_state == ST_RESP && bus.bus_rsp_valid) begin
                if (bus.bus_err)  r_rdata <= 32'h0000_0000;
                else if (!r_we)   r_rdata <= w_rdata;
            end else if (r_state == ST_RESP && w_timeout) begin
                r_rdata <= 32'h0000_0000;
            end
        end
    end

    // RESP-cycle counter, cleared when the request is accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 16'h0000;
        end else if (r_state == ST_REQ && bus.bus_req_ready) begin
            r_cnt <= 16'h0000;
        end else if (r_state == ST_RESP && !bus.bus_rsp_valid && !w_timeout) begin
            r_cnt <= r_cnt + 16'h0001;
        end
    end

    assign ReadData          = r_rdata;
    assign Fault             = r_fault;
    assign FaultCode         = r_fault_code;
    assign bus.bus_req_valid = r_req_valid;
    assign bus.bus_addr      = r_addr;
    assign bus.bus_we        = r_we;
    assign bus.bus_be        = r_be;
    assign bus.bus_wdata     = r_wdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboarded bench for dmem_bridge: a small bus responder with programmable
// ready/response delays, one task per scenario.
module tb_dmem_bridge;
    import dmem_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [1:0]  Size;
    logic [31:0] Mem_WrAddr, Mem_WrData, ReadData;
    logic        Stall, Fault;
    logic [1:0]  FaultCode;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] rd;
        logic        fault;
        logic [1:0]  code;
        int          stalls;
    } exp_t;
    exp_t sb[$];

    int          obs_stalls;
    logic [31:0] obs_rd, obs_addr, obs_wdata;
    logic        obs_fault, obs_we, obs_saw;
    logic [1:0]  obs_code;
    logic [3:0]  obs_be;

    dmem_bridge_if bus();

    dmem_bridge #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Size(Size),
        .Mem_WrAddr(Mem_WrAddr), .Mem_WrData(Mem_WrData), .ReadData(ReadData),
        .Stall(Stall), .Fault(Fault), .FaultCode(FaultCode), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic clear_bus();
        bus.bus_req_ready = 1'b0;
        bus.bus_rsp_valid = 1'b0;
        bus.bus_rdata     = 32'h0000_0000;
        bus.bus_err       = 1'b0;
    endtask

    // Drives one access from a posedge+1 point and records what the bridge does until DONE.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err,
                              input int ready_wait, input int rsp_wait,
                              input bit respond, input bit noise);
        int wcnt = 0;
        int rcnt = 0;
        bit accepted = 1'b0, responded = 1'b0, done = 1'b0, acc_now, rsp_now;
        MemRead = rd; MemWrite = wr; Size = sz; Mem_WrAddr = addr; Mem_WrData = wdata;
        obs_saw = 1'b0; obs_stalls = 0; obs_addr = 32'h0; obs_wdata = 32'h0;
        obs_be = 4'h0; obs_we = 1'b0; obs_rd = 32'h0; obs_fault = 1'b0; obs_code = 2'b00;
        for (int c = 0; c < 100 && !done; c++) begin
            acc_now = 1'b0; rsp_now = 1'b0;
            clear_bus();
            if (accepted) begin
                if (respond && !responded) begin
                    if (rcnt < rsp_wait) rcnt++;
                    else begin
                        bus.bus_rsp_valid = 1'b1; bus.bus_rdata = rdata; bus.bus_err = err;
                        rsp_now = 1'b1;
                    end
                end
            end else if (bus.bus_req_valid) begin
                if (noise) begin
                    bus.bus_rsp_valid = 1'b1; bus.bus_rdata = 32'hBAD0_BAD0; bus.bus_err = 1'b1;
                end
                if (wcnt < ready_wait) wcnt++;
                else begin bus.bus_req_ready = 1'b1; acc_now = 1'b1; end
            end
            @(negedge clk);
            if (bus.bus_req_valid && !obs_saw) begin
                obs_saw = 1'b1; obs_addr = bus.bus_addr; obs_be = bus.bus_be;
                obs_wdata = bus.bus_wdata; obs_we = bus.bus_we;
            end
            if (Stall) obs_stalls++;
            else begin obs_rd = ReadData; obs_fault = Fault; obs_code = FaultCode; done = 1'b1; end
            @(posedge clk); #1;
            if (acc_now) accepted = 1'b1;
            if (rsp_now) responded = 1'b1;
        end
        clear_bus();
        MemRead = 1'b0; MemWrite = 1'b0;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL access_done: no DONE within 100 cycles (addr %h), required DONE", addr);
        end
    endtask

    task automatic check_result(input string name);
        exp_t e;
        e = sb.pop_front();
        n_vec++;
        if (obs_rd !== e.rd) begin n_err++; $display("FAIL %s.ReadData: got %h required %h", name, obs_rd, e.rd); end
        n_vec++;
        if (obs_fault !== e.fault || obs_code !== e.code) begin
            n_err++;
            $display("FAIL %s.fault: got %b/%b required %b/%b", name, obs_fault, obs_code, e.fault, e.code);
        end
        n_vec++;
        if (obs_stalls != e.stalls) begin n_err++; $display("FAIL %s.stalls: got %0d required %0d", name, obs_stalls, e.stalls); end
    endtask

    task automatic test_reset();
        reset = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; Size = SZ_WORD;
        Mem_WrAddr = 32'h100; Mem_WrData = 32'h0; clear_bus();
        #12;
        n_vec++;
        if (Stall !== 1'b0) begin n_err++; $display("FAIL reset.stall: got %b required 0", Stall); end
        n_vec++;
        if ({ReadData, Fault, FaultCode} !== 35'h0) begin
            n_err++; $display("FAIL reset.outputs: got %h/%b/%b required 0", ReadData, Fault, FaultCode);
        end
        n_vec++;
        if ({bus.bus_req_valid, bus.bus_addr, bus.bus_we, bus.bus_be, bus.bus_wdata} !== 70'h0) begin
            n_err++; $display("FAIL reset.bus: got v%b a%h we%b be%b wd%h required 0", bus.bus_req_valid,
                              bus.bus_addr, bus.bus_we, bus.bus_be, bus.bus_wdata);
        end
        MemRead = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_word();
        sb.push_back('{32'hDEAD_BEEF, 1'b0, FC_NONE, 3});
        run_access(1'b1, 1'b0, SZ_WORD, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 0, 1'b1, 1'b0);
        n_vec++;
        if (obs_be !== 4'b1111 || obs_addr !== 32'h100 || obs_we !== 1'b0) begin
            n_err++; $display("FAIL load_word.req: got be%b a%h we%b required be1111 a00000100 we0", obs_be, obs_addr, obs_we);
        end
        check_result("load_word");
    endtask

    task automatic test_store_byte();
        sb.push_back('{32'hDEAD_BEEF, 1'b0, FC_NONE, 3});
        run_access(1'b0, 1'b1, SZ_BYTE, 32'h203, 32'h0000_00A5, 32'h1234_5678, 1'b0, 0, 0, 1'b1, 1'b0);
        n_vec++;
        if (obs_be !== 4'b1000 || obs_addr !== 32'h200 || obs_we !== 1'b1 || obs_wdata !== 32'hA5A5_A5A5) begin
            n_err++; $display("FAIL store_byte.req: got be%b a%h we%b wd%h required be1000 a00000200 we1 wda5a5a5a5",
                              obs_be, obs_addr, obs_we, obs_wdata);
        end
        check_result("store_byte");
    endtask

    task automatic test_load_half();
        sb.push_back('{32'h0000_8001, 1'b0, FC_NONE, 5});
        run_access(1'b1, 1'b0, SZ_HALF, 32'h102, 32'h0, 32'h8001_7FFF, 1'b0, 2, 0, 1'b1, 1'b1);
        n_vec++;
        if (obs_be !== 4'b1100 || obs_addr !== 32'h100) begin
            n_err++; $display("FAIL load_half.req: got be%b a%h required be1100 a00000100", obs_be, obs_addr);
        end
        check_result("load_half");
    endtask

    task automatic test_misaligned();
        sb.push_back('{32'h0, 1'b1, FC_MISALIGN, 1});
        run_access(1'b1, 1'b0, SZ_WORD, 32'h101, 32'h0, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b1, 1'b0);
        n_vec++;
        if (obs_saw !== 1'b0) begin n_err++; $display("FAIL misalign.noreq: got req_valid 1 required 0"); end
        check_result("misalign_word");
        @(negedge clk);
        n_vec++;
        if (Fault !== 1'b0) begin n_err++; $display("FAIL misalign.pulse: got Fault %b after DONE required 0", Fault); end
        @(posedge clk); #1;
        sb.push_back('{32'h0, 1'b1, FC_MISALIGN, 1});
        run_access(1'b1, 1'b0, SZ_HALF, 32'h201, 32'h0, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b1, 1'b0);
        check_result("misalign_half");
    endtask

    task automatic test_bus_error();
        sb.push_back('{32'h0000_0033, 1'b0, FC_NONE, 3});
        run_access(1'b1, 1'b0, SZ_BYTE, 32'h001, 32'h0, 32'h1122_3344, 1'b0, 0, 0, 1'b1, 1'b0);
        check_result("load_byte");
        sb.push_back('{32'h0, 1'b1, FC_BUSERR, 3});
        run_access(1'b1, 1'b0, SZ_BYTE, 32'h001, 32'h0, 32'h1122_3344, 1'b1, 0, 0, 1'b1, 1'b0);
        check_result("bus_error");
    endtask

    task automatic test_timeout();
        sb.push_back('{32'h7766_5544, 1'b0, FC_NONE, 6});
        run_access(1'b1, 1'b0, SZ_WORD, 32'h040, 32'h0, 32'h7766_5544, 1'b0, 0, TO - 1, 1'b1, 1'b0);
        check_result("last_cycle_rsp");
        sb.push_back('{32'h0, 1'b1, FC_TIMEOUT, 6});
        run_access(1'b1, 1'b0, SZ_WORD, 32'h044, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0);
        check_result("timeout");
        bus.bus_rsp_valid = 1'b1; bus.bus_rdata = 32'hFFFF_FFFF; bus.bus_err = 1'b1;
        @(negedge clk);
        n_vec++;
        if (Stall !== 1'b0) begin n_err++; $display("FAIL late_rsp.stall: got %b required 0", Stall); end
        @(posedge clk); #1;
        clear_bus();
        @(negedge clk);
        n_vec++;
        if (Fault !== 1'b0 || ReadData !== 32'h0) begin
            n_err++; $display("FAIL late_rsp.ignored: got Fault %b ReadData %h required 0/00000000", Fault, ReadData);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        sb.push_back('{32'h0, 1'b0, FC_NONE, 3});
        run_access(1'b1, 1'b1, SZ_HALF, 32'h002, 32'h1234_ABCD, 32'h5555_5555, 1'b0, 0, 0, 1'b1, 1'b0);
        n_vec++;
        if (obs_be !== 4'b1100 || obs_we !== 1'b1 || obs_wdata !== 32'hABCD_ABCD) begin
            n_err++; $display("FAIL both_high.req: got be%b we%b wd%h required be1100 we1 wdabcdabcd", obs_be, obs_we, obs_wdata);
        end
        check_result("both_high_store");
        sb.push_back('{32'hCAFE_F00D, 1'b0, FC_NONE, 4});
        run_access(1'b1, 1'b0, 2'b11, 32'h104, 32'h0, 32'hCAFE_F00D, 1'b0, 0, 1, 1'b1, 1'b0);
        n_vec++;
        if (obs_be !== 4'b1111) begin n_err++; $display("FAIL size11.be: got %b required 1111", obs_be); end
        check_result("size11_load");
    endtask

    task automatic test_reset_mid();
        sb.push_back('{32'h5555_AAAA, 1'b0, FC_NONE, 3});
        run_access(1'b1, 1'b0, SZ_WORD, 32'h000, 32'h0, 32'h5555_AAAA, 1'b0, 0, 0, 1'b1, 1'b0);
        check_result("pre_reset_load");
        MemRead = 1'b1; Size = SZ_WORD; Mem_WrAddr = 32'h300;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.bus_req_valid !== 1'b1) begin n_err++; $display("FAIL mid_reset.in_req: got req_valid %b required 1", bus.bus_req_valid); end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (bus.bus_req_valid !== 1'b0 || Stall !== 1'b0) begin
            n_err++; $display("FAIL mid_reset.async: got req_valid %b Stall %b required 0/0", bus.bus_req_valid, Stall);
        end
        n_vec++;
        if ({ReadData, Fault, FaultCode, bus.bus_addr, bus.bus_we, bus.bus_be, bus.bus_wdata} !== 104'h0) begin
            n_err++; $display("FAIL mid_reset.values: got rd%h f%b fc%b a%h we%b be%b wd%h required 0", ReadData,
                              Fault, FaultCode, bus.bus_addr, bus.bus_we, bus.bus_be, bus.bus_wdata);
        end
        bus.bus_rsp_valid = 1'b1; bus.bus_rdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        MemRead = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        clear_bus();
        @(negedge clk);
        n_vec++;
        if (Stall !== 1'b0 || Fault !== 1'b0 || ReadData !== 32'h0 || bus.bus_req_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_reset.idle: got Stall %b Fault %b rd %h v %b required 0", Stall, Fault, ReadData, bus.bus_req_valid);
        end
        @(posedge clk); #1;
        sb.push_back('{32'h0BAD_F00D, 1'b0, FC_NONE, 3});
        run_access(1'b1, 1'b0, SZ_WORD, 32'h300, 32'h0, 32'h0BAD_F00D, 1'b0, 0, 0, 1'b1, 1'b0);
        check_result("post_reset_load");
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_load_half();
        test_misaligned();
        test_bus_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bus bridge between the single-cycle RISC-V datapath and a valid/ready memory bus. It takes the datapath's load/store address, store data and access size, and runs one bus transaction per memory instruction. While the transaction is in flight it stalls the PC register and register-file write. It returns a lane-aligned read word, so the datapath's existing sign/zero-extend logic consumes it unchanged.

## Interface
- TIMEOUT, default 64: maximum RESP-state cycles before the access is aborted with a fault; legal range 2..65535.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- MemRead  in  1  current instruction is a load.
- MemWrite  in  1  current instruction is a store. MemRead and MemWrite both high is treated as a store.
- Size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- Mem_WrAddr  in  32  byte address (the datapath ALU result).
- Mem_WrData  in  32  store data, valid in the low bits for byte/half accesses.
- ReadData  out  32  load result, shifted so the addressed byte or half sits at bit 0.
- Stall  out  1  high means the PC and register write must hold this cycle.
- Fault  out  1  one-cycle pulse in DONE when the access failed.
- FaultCode  out  2  valid with Fault: 01 misaligned, 10 bus error, 11 timeout.
- bus_req_valid  out  1  request valid.
- bus_req_ready  in  1  bus accepts the request.
- bus_addr  out  32  request address, word aligned ({addr[31:2],2'b00}).
- bus_we  out  1  1 = write.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated write data.
- bus_rsp_valid  in  1  response valid.
- bus_rdata  in  32  response data.
- bus_err  in  1  response error, qualified by bus_rsp_valid.

## Operation
- FSM states: IDLE, REQ, RESP, DONE. Encoding is free.
- **IDLE**
  - Access = MemRead|MemWrite. With Access high, Stall=1 combinationally.
  - On that clock edge, capture address, write data, byte enables, we and size into registers.
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]≠0): go to DONE with FaultCode=01. No bus activity.
  - Otherwise go to REQ.
  - Access low: Stall=0 and the FSM stays in IDLE.
- **REQ**
  - bus_req_valid=1; the request fields come from registers and stay stable until accepted.
  - On bus_req_valid&bus_req_ready, go to RESP and clear the timeout counter.
  - bus_rsp_valid is ignored in REQ.
- **RESP**
  - Wait for bus_rsp_valid, then capture the read data and bus_err, and go to DONE.
  - A write response also completes the access; its data is discarded.
  - The counter increments each RESP cycle. When counter reaches TIMEOUT-1 without a response, go to DONE with FaultCode=11.
- **DONE**
  - Stall=0, so the instruction commits.
  - Fault pulses if any fault occurred. FaultCode is 10 when bus_err=1.
  - Always return to IDLE. Access inputs are ignored in DONE, so the same instruction is never relaunched.
- Byte enables:
  - Byte: 0001<<addr[1:0].
  - Half: 0011<<{addr[1],1'b0}.
  - Word: 1111.
- Write data:
  - Byte: replicate data[7:0] ×4.
  - Half: replicate data[15:0] ×2.
  - Word: data unchanged.
- Read data is registered in RESP:
  - Byte: rdata>>(8*addr[1:0]), upper 24 bits zero.
  - Half: rdata>>(16*addr[1]), upper 16 bits zero.
  - Word: rdata unchanged.
  - On any fault, ReadData=0.
- ReadData holds its value until the next capture.

## Timing
- Reset values: FSM=IDLE, ReadData=0, Fault=0, FaultCode=00, bus_req_valid=0, bus_addr=0, bus_we=0, bus_be=0, bus_wdata=0, counter=0. Stall=0 while in reset (it is combinational from Access and state).
- Minimum aligned access, counting the first access cycle as C0:
  - C0: IDLE, Stall=1.
  - C1: REQ, ready=1.
  - C2: RESP, rsp_valid=1.
  - C3: DONE, Stall=0.
  - Result: 3 stall cycles; the instruction commits at the end of C3.
- Misaligned access: C0 IDLE, C1 DONE. This gives 1 stall cycle.
- Each cycle of ready low in REQ, or rsp_valid low in RESP, adds exactly one stall cycle.
- Only one transaction is ever outstanding.
- Reset asserted mid-operation:
  - The FSM goes to IDLE immediately and bus_req_valid drops asynchronously.
  - A late bus_rsp_valid arriving in IDLE or REQ is ignored.

## Structure
- Shared package `dmem_pkg` holds:
  - Size codes SZ_BYTE/SZ_HALF/SZ_WORD.
  - FaultCode values FC_MISALIGN/FC_BUSERR/FC_TIMEOUT.
  - The FSM state type.
- One combinational sub-module, `dmem_lane`, computes the byte enables, replicated write data and read shift from size and addr[1:0].
- The FSM, capture registers and timeout counter live in dmem_bridge.

## Test plan
- Load word, addr 0x100, ready=1, rsp_valid the cycle after accept with rdata 0xDEADBEEF -> bus_be=1111, bus_addr=0x100, Stall high 3 cycles, ReadData=0xDEADBEEF in DONE.
- Store byte 0xA5 to 0x203 -> bus_be=1000, bus_wdata=0xA5A5A5A5, bus_we=1, bus_addr=0x200.
- Load half from 0x102 with rdata 0x8001_7FFF and ready low 2 cycles -> Stall high 5 cycles, ReadData=0x00008001.
- Word load at 0x101 -> no bus_req_valid, Fault pulse with FaultCode=01 one cycle after access, ReadData=0.
- TIMEOUT=4, request accepted, no response -> DONE after 4 RESP cycles with FaultCode=11. A later rsp_valid is ignored.
- Reset asserted while in REQ -> bus_req_valid=0 immediately, FSM IDLE, all outputs at their reset values. A new access after reset completes normally.
